dec_scan_arbiter: RTL and testbench



---
 rtl/dec_scan_arbiter_pkg.sv | 15 +
 rtl/dec_scan_arbiter_if.sv | 23 ++
 rtl/dec_scan_arbiter_rr_pick.sv | 30 +++
 rtl/dec_scan_arbiter.sv | 114 +++++++++++
 tb/tb_dec_scan_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dec_scan_arbiter_pkg.sv
// dec_arb_pkg: shared sizes and FSM state type for the decoder scan arbiter.
//   N_REQ  - number of requesters sharing the 3-to-8 decoder
//   IDX_W  - width of a requester index / decoder select
//   CNT_W  - width of the hold and gap counters
package dec_arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/dec_scan_arbiter_if.sv
// dec_scan_arbiter_if: request side and decoder side of the scan arbiter.
//   req    - request vector, bit i = requester i
//   lock   - hold-extend request from the current owner
//   dec_E  - decoder enable
//   dec_In - decoder select (granted index)
//   grant  - one-hot grant, decoder function of dec_E/dec_In
//   busy   - arbiter not idle
// master drives requests, slave (the arbiter) drives the decoder controls.
import dec_arb_pkg::*;

interface dec_scan_arbiter_if;
    logic [N_REQ-1:0] req;
    logic             lock;
    logic             dec_E;
    logic [IDX_W-1:0] dec_In;
    logic [N_REQ-1:0] grant;
    logic             busy;

    modport master (output req, output lock,
                    input dec_E, input dec_In, input grant, input busy);
    modport slave  (input req, input lock,
                    output dec_E, output dec_In, output grant, output busy);
endinterface

// File: rtl/dec_scan_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req   - request vector
//   ptr   - index with highest priority this round
//   valid - at least one request set
//   idx   - first set bit found searching ptr, ptr+1, ... modulo N_REQ
import dec_arb_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is the
    // last assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/dec_scan_arbiter.sv
// dec_scan_arbiter: round-robin arbiter sharing one 3-to-8 decoder among
// 8 requesters. Each tenure is bounded to HOLD_MAX cycles and followed by
// GAP_CYC guard cycles with the decoder disabled plus one arbitration cycle.
// Ports:
//   clka - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of dec_scan_arbiter_if (req, lock in; dec_E, dec_In,
//          grant, busy out)
// Optional build macro DEC_ARB_LOCK_EN: when defined, an owner that holds
// lock high at the end of its tenure keeps the grant until lock or its
// request drops. When undefined, lock is ignored and HOLD_MAX is strict.
import dec_arb_pkg::*;

module dec_scan_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int GAP_CYC  = 1
) (
    input logic                clka,
    input logic                rst,
    dec_scan_arbiter_if.slave  bus
);
    state_t           state_q, state_d;
    logic             dec_e_q, dec_e_d;
    logic [IDX_W-1:0] dec_in_q, dec_in_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             at_limit;
    logic             extend;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = bus.req[dec_in_q];
    assign at_limit  = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

`ifdef DEC_ARB_LOCK_EN
    assign extend = at_limit && bus.lock && owner_req;
`else
    assign extend = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dec_e_d    = dec_e_q;
        dec_in_d   = dec_in_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    dec_in_d   = pick_idx;
                    dec_e_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || (at_limit && !extend)) begin
                    dec_e_d    = 1'b0;
                    ptr_d      = dec_in_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYC > 0) ? GAP : IDLE;
                end else if (!at_limit) begin
                    // At the limit only an extended tenure gets here; the
                    // counter then saturates.
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= IDLE;
            dec_e_q    <= 1'b0;
            dec_in_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            dec_e_q    <= dec_e_d;
            dec_in_q   <= dec_in_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.dec_E  = dec_e_q;
    assign bus.dec_In = dec_in_q;
    assign bus.grant  = dec_e_q ? (N_REQ'(1) << dec_in_q) : '0;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_dec_scan_arbiter.sv
// tb_dec_scan_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a tenure-level model.
module tb_dec_scan_arbiter;
    localparam int HOLD_MAX = 4;
    localparam int GAP_CYC  = 1;
`ifdef DEC_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clka = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    dec_scan_arbiter_if bus ();

    dec_scan_arbiter #(.HOLD_MAX(HOLD_MAX), .GAP_CYC(GAP_CYC)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    // Model: who owns the decoder, how many cycles it has shown, how many
    // guard cycles remain, and where the next search starts.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_in    = 0;

    always @(posedge clka) begin
        if (rst) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_in = 0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] ||
                (m_held >= HOLD_MAX && !(LOCK_EN && bus.lock))) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = GAP_CYC;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.req != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                if (m_owner < 0 && bus.req[(m_ptr + i) % 8]) begin
                    m_owner = (m_ptr + i) % 8;
                    m_in    = m_owner;
                    m_held  = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clka) begin
        if (chk_en) begin
            check("model_dec_E", 32'(bus.dec_E), 32'(m_owner >= 0));
            check("model_dec_In", 32'(bus.dec_In), 32'(m_in));
            check("model_grant", 32'(bus.grant),
                  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_gap > 0)));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.lock = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst_dec_E", 32'(bus.dec_E), 32'd0);
        check("rst_dec_In", 32'(bus.dec_In), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Single requester 2: 4-cycle tenure, 2 low cycles, re-grant.
        bus.req = 8'h04;
        tick(1);
        check("t1_E", 32'(bus.dec_E), 32'd1);
        check("t1_In", 32'(bus.dec_In), 32'd2);
        check("t1_grant", 32'(bus.grant), 32'h04);
        tick(3);
        check("t1_grant_c4", 32'(bus.grant), 32'h04);
        tick(1);
        check("t1_rel_E", 32'(bus.dec_E), 32'd0);
        check("t1_gap_busy", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        tick(1);
        check("t1_regrant", 32'(bus.grant), 32'h04);

        // All requesting: indices 0..7 then 0, one grant every 6 cycles.
        do_reset();
        bus.req = 8'hFF;
        tick(1);
        for (int k = 0; k < 9; k++) begin
            check("t2_In", 32'(bus.dec_In), 32'(k % 8));
            check("t2_E", 32'(bus.dec_E), 32'd1);
            tick(4);
            check("t2_low", 32'(bus.dec_E), 32'd0);
            tick(2);
        end

        // Early drop of requester 0, then re-grant of 0 via wrap search.
        do_reset();
        bus.req = 8'h01;
        tick(2);
        check("t3_held", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        tick(1);
        check("t3_drop_E", 32'(bus.dec_E), 32'd0);
        bus.req = 8'h01;
        tick(1);
        check("t3_gap_E", 32'(bus.dec_E), 32'd0);
        tick(1);
        check("t3_regrant_In", 32'(bus.dec_In), 32'd0);
        check("t3_regrant_E", 32'(bus.dec_E), 32'd1);

        // Wrap from 6 to 7 to 0.
        do_reset();
        bus.req = 8'h40;
        tick(1);
        check("t4_In6", 32'(bus.dec_In), 32'd6);
        bus.req = 8'h81;
        tick(3);
        check("t4_In7", 32'(bus.dec_In), 32'd7);
        tick(6);
        check("t4_In0", 32'(bus.dec_In), 32'd0);
        check("t4_E0", 32'(bus.dec_E), 32'd1);

        // Reset in the middle of a tenure.
        do_reset();
        bus.req = 8'h20;
        tick(2);
        check("t5_In5", 32'(bus.dec_In), 32'd5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_E", 32'(bus.dec_E), 32'd0);
        check("t5_rst_In", 32'(bus.dec_In), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 8'h10;
        tick(1);
        check("t5_In4", 32'(bus.dec_In), 32'd4);

        // Lock extension on requester 3 with requester 0 pending.
        do_reset();
        bus.lock = 1'b1;
        bus.req  = 8'h08;
        tick(1);
        check("t6_In3", 32'(bus.dec_In), 32'd3);
        bus.req = 8'h09;
        tick(4);
        check("t6_after4_E", 32'(bus.dec_E), LOCK_EN ? 32'd1 : 32'd0);
        if (LOCK_EN) begin
            tick(3);
            check("t6_extended", 32'(bus.grant), 32'h08);
            bus.lock = 1'b0;
            tick(1);
            check("t6_rel", 32'(bus.dec_E), 32'd0);
        end
        tick(2);
        check("t6_next_In0", 32'(bus.dec_In), 32'd0);
        check("t6_next_E", 32'(bus.dec_E), 32'd1);

        // Randomized run against the model.
        bus.lock = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            case ($urandom_range(0, 7))
                0:       bus.req = 8'(1 << $urandom_range(0, 7));
                1:       bus.req = 8'h00;
                2:       bus.req = 8'($urandom);
                3:       bus.req = bus.req & ~8'(1 << $urandom_range(0, 7));
                default: bus.req = bus.req;
            endcase
            bus.lock = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
